// File: rtl/uart_bus_bridge.sv
// UART command bridge: assembles W/R/H/G byte commands, masters one bus word
// access per command and returns ACK/NAK or read data over the UART byte interface.
module uart_bus_bridge #(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic [31:0] o_addr,
  output logic [31:0] o_data_wr,
  output logic [3:0]  o_wr,
  output logic        o_rd,
  input  logic [31:0] i_data_rd,
  output logic        o_cpu_hold,
  output logic        o_rx_drop
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [7:0] CMD_W = 8'h57;
  localparam logic [7:0] CMD_R = 8'h52;
  localparam logic [7:0] CMD_H = 8'h48;
  localparam logic [7:0] CMD_G = 8'h47;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'h15;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD_ADDR, S_CMD_DATA, S_BUS_WR, S_BUS_RD, S_RD_WAIT, S_TX
  } state_t;

  state_t          state_q, state_d;
  logic [1:0]      bcnt_q, bcnt_d;
  logic            is_wr_q, is_wr_d;
  logic [31:0]     adr_sh_q, adr_sh_d;
  logic [31:0]     dat_sh_q, dat_sh_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     txbuf_q, txbuf_d;
  logic [2:0]      txcnt_q, txcnt_d;
  logic            hold_q, hold_d;
  logic            drop_q, drop_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [1:0]      lat_q, lat_d;
  logic            rx_open;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      is_wr_q  <= 1'b0;
      adr_sh_q <= '0;
      dat_sh_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      txbuf_q  <= '0;
      txcnt_q  <= '0;
      hold_q   <= 1'b1;
      drop_q   <= 1'b0;
      tmo_q    <= '0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      is_wr_q  <= is_wr_d;
      adr_sh_q <= adr_sh_d;
      dat_sh_q <= dat_sh_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      txbuf_q  <= txbuf_d;
      txcnt_q  <= txcnt_d;
      hold_q   <= hold_d;
      drop_q   <= drop_d;
      tmo_q    <= tmo_d;
      lat_q    <= lat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    is_wr_d  = is_wr_q;
    adr_sh_d = adr_sh_q;
    dat_sh_d = dat_sh_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    txbuf_d  = txbuf_q;
    txcnt_d  = txcnt_q;
    hold_d   = hold_q;
    tmo_d    = tmo_q;
    lat_d    = lat_q;
    rx_open  = (state_q == S_IDLE) || (state_q == S_CMD_ADDR) || (state_q == S_CMD_DATA);
    drop_d   = i_rx_valid && !rx_open;

    case (state_q)
      S_IDLE: begin
        tmo_d  = '0;
        bcnt_d = '0;
        if (i_rx_valid) begin
          txcnt_d = 3'd1;
          state_d = S_TX;
          case (i_rx_data)
            CMD_W: begin is_wr_d = 1'b1; state_d = S_CMD_ADDR; end
            CMD_R: begin is_wr_d = 1'b0; state_d = S_CMD_ADDR; end
            CMD_H: begin hold_d = 1'b1; txbuf_d = {24'h0, ACK}; end
            CMD_G: begin hold_d = 1'b0; txbuf_d = {24'h0, ACK}; end
            default: txbuf_d = {24'h0, NAK};
          endcase
        end
      end
      S_CMD_ADDR, S_CMD_DATA: begin
        if (i_rx_valid) begin
          // an arriving byte always beats a simultaneous timeout expiry
          tmo_d  = '0;
          bcnt_d = bcnt_q + 2'd1;
          if (state_q == S_CMD_ADDR) begin
            adr_sh_d = {i_rx_data, adr_sh_q[31:8]};
            if (bcnt_q == 2'd3) begin
              if (is_wr_q) begin
                state_d = S_CMD_DATA;
              end else begin
                addr_d  = {i_rx_data, adr_sh_q[31:10], 2'b00};
                state_d = S_BUS_RD;
              end
            end
          end else begin
            dat_sh_d = {i_rx_data, dat_sh_q[31:8]};
            if (bcnt_q == 2'd3) begin
              wdata_d = {i_rx_data, dat_sh_q[31:8]};
              addr_d  = {adr_sh_q[31:2], 2'b00};
              state_d = S_BUS_WR;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_BUS_WR: begin
        txbuf_d = {24'h0, ACK};
        txcnt_d = 3'd1;
        state_d = S_TX;
      end
      S_BUS_RD: begin
        lat_d   = '0;
        state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (lat_q == 2'(READ_LATENCY - 1)) begin
          txbuf_d = i_data_rd;
          txcnt_d = 3'd4;
          state_d = S_TX;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end
      S_TX: begin
        // LSB byte is always on o_tx_data; shift after each accepted byte
        if (i_tx_ready) begin
          txbuf_d = {8'h00, txbuf_q[31:8]};
          txcnt_d = txcnt_q - 3'd1;
          if (txcnt_q == 3'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign o_tx_data  = txbuf_q[7:0];
  assign o_tx_valid = (state_q == S_TX);
  assign o_addr     = addr_q;
  assign o_data_wr  = wdata_q;
  assign o_wr       = (state_q == S_BUS_WR) ? 4'hF : 4'h0;
  assign o_rd       = (state_q == S_BUS_RD);
  assign o_cpu_hold = hold_q;
  assign o_rx_drop  = drop_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomized bench for uart_bus_bridge: command-level reference model with
// expected tx-byte / bus-access queues compared against monitored DUT traffic.
module tb_uart_bus_bridge;
  localparam int RL  = 1;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [31:0] addr, data_wr, rdq;
  logic [3:0]  wr;
  logic        rd, cpu_hold, rx_drop;

  always #5 clk = ~clk;

  uart_bus_bridge #(.READ_LATENCY(RL), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_addr(addr), .o_data_wr(data_wr), .o_wr(wr), .o_rd(rd),
    .i_data_rd(rdq), .o_cpu_hold(cpu_hold), .o_rx_drop(rx_drop)
  );

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]  exp_tx[$], obs_tx[$];
  logic [63:0] exp_wr[$], obs_wr[$];
  logic [31:0] exp_rd[$], obs_rd[$];
  logic [31:0] bus_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];
  logic        exp_hold = 1'b1;
  bit          force_low = 1'b0;
  int          drop_cnt = 0;
  int          cyc = 0, last_rx_cyc = 0, wr_cyc = 0;
  bit          ack_pend = 0, prev_txv = 0, prev_stall = 0, prev_wr = 0, prev_rd = 0;
  logic [7:0]  prev_txd = 8'h00;
  logic [31:0] prev_addr = 32'h0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5AA5A5;
  endfunction

  function automatic logic [31:0] bus_lookup(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_lookup(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Bus slave: one-cycle read latency, junk on every other cycle
  always @(posedge clk) rdq <= rd ? bus_lookup(addr) : $urandom;

  initial forever begin
    @(negedge clk);
    tx_ready = force_low ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor samples just before each rising edge
  initial forever begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      prev_stall = 0; prev_wr = 0; prev_rd = 0; prev_txv = 0; ack_pend = 0;
    end else begin
      cyc++;
      if (rx_valid) last_rx_cyc = cyc;
      if (rx_drop) drop_cnt++;
      if (prev_stall) chk("tx_stable", 64'(tx_data), 64'(prev_txd));
      if (prev_wr) chk("wr_addr_hold", 64'(addr), 64'(prev_addr));
      if (prev_rd) chk("rd_addr_hold", 64'(addr), 64'(prev_addr));
      prev_wr = 0;
      prev_rd = 0;
      if (wr != 4'h0) begin
        chk("wr_strobe", 64'(wr), 64'(4'hF));
        chk("wr_rd_excl", 64'(rd), 64'(0));
        chk("wr_latency", 64'(cyc - last_rx_cyc), 64'(1));
        obs_wr.push_back({addr, data_wr});
        bus_mem[addr] = data_wr;
        prev_wr = 1; prev_addr = addr; wr_cyc = cyc; ack_pend = 1;
      end
      if (rd) begin
        obs_rd.push_back(addr);
        prev_rd = 1; prev_addr = addr;
      end
      if (tx_valid && !prev_txv && ack_pend) begin
        chk("ack_latency", 64'(cyc - wr_cyc), 64'(1));
        ack_pend = 0;
      end
      if (tx_valid && tx_ready) obs_tx.push_back(tx_data);
      prev_stall = tx_valid && !tx_ready;
      prev_txd   = tx_data;
      prev_txv   = tx_valid;
    end
  end

  // Callers are always at a falling edge; a zero gap yields back-to-back strobes
  task automatic send_byte(input logic [7:0] b, input int max_gap);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat ($urandom_range(0, max_gap)) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], 6);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] aw;
    aw = {a[31:2], 2'b00};
    send_byte(8'h57, 6); send_word(a); send_word(d);
    exp_wr.push_back({aw, d});
    exp_tx.push_back(8'h06);
    ref_mem[aw] = d;
  endtask

  task automatic do_read(input logic [31:0] a);
    logic [31:0] aw, v;
    aw = {a[31:2], 2'b00};
    v  = ref_lookup(aw);
    send_byte(8'h52, 6); send_word(a);
    exp_rd.push_back(aw);
    for (int i = 0; i < 4; i++) exp_tx.push_back(v[8*i +: 8]);
  endtask

  task automatic do_hold(input bit h);
    send_byte(h ? 8'h48 : 8'h47, 6);
    exp_hold = h;
    exp_tx.push_back(8'h06);
  endtask

  task automatic do_bad(input logic [7:0] b);
    send_byte(b, 6);
    exp_tx.push_back(8'h15);
  endtask

  task automatic finish_cmd(input string tag);
    for (int i = 0; i < 3000 && obs_tx.size() < exp_tx.size(); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk({tag, "_tx_count"}, 64'(obs_tx.size()), 64'(exp_tx.size()));
    while (obs_tx.size() > 0 && exp_tx.size() > 0)
      chk({tag, "_tx_byte"}, 64'(obs_tx.pop_front()), 64'(exp_tx.pop_front()));
    chk({tag, "_wr_count"}, 64'(obs_wr.size()), 64'(exp_wr.size()));
    while (obs_wr.size() > 0 && exp_wr.size() > 0)
      chk({tag, "_wr_addr_data"}, obs_wr.pop_front(), exp_wr.pop_front());
    chk({tag, "_rd_count"}, 64'(obs_rd.size()), 64'(exp_rd.size()));
    while (obs_rd.size() > 0 && exp_rd.size() > 0)
      chk({tag, "_rd_addr"}, 64'(obs_rd.pop_front()), 64'(exp_rd.pop_front()));
    chk({tag, "_hold"}, 64'(cpu_hold), 64'(exp_hold));
    obs_tx.delete(); exp_tx.delete(); obs_wr.delete(); exp_wr.delete();
    obs_rd.delete(); exp_rd.delete();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_tx_valid"}, 64'(tx_valid), 64'(0));
    chk({tag, "_tx_data"},  64'(tx_data),  64'(0));
    chk({tag, "_addr"},     64'(addr),     64'(0));
    chk({tag, "_data_wr"},  64'(data_wr),  64'(0));
    chk({tag, "_wr"},       64'(wr),       64'(0));
    chk({tag, "_rd"},       64'(rd),       64'(0));
    chk({tag, "_hold"},     64'(cpu_hold), 64'(1));
    chk({tag, "_rx_drop"},  64'(rx_drop),  64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool[6];
    logic [7:0]  b;
    int          d0;

    bus_mem[32'h104] = 32'h12345678;
    ref_mem[32'h104] = 32'h12345678;

    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    do_write(32'h00000100, 32'hDEADBEEF); finish_cmd("w100");
    do_read(32'h00000104);                finish_cmd("r104");
    do_hold(1'b0);                        finish_cmd("go");
    do_hold(1'b1);                        finish_cmd("hold");
    do_bad(8'h00);                        finish_cmd("nak");

    // Stalled reply: a byte arriving during TX must be dropped
    force_low = 1'b1;
    do_read(32'h00000104);
    for (int i = 0; i < 100 && !tx_valid; i++) @(negedge clk);
    chk("stall_tx_valid", 64'(tx_valid), 64'(1));
    d0 = drop_cnt;
    send_byte(8'h47, 0);
    repeat (50) @(negedge clk);
    chk("stall_rx_drop", 64'(drop_cnt - d0), 64'(1));
    chk("stall_no_tx", 64'(obs_tx.size()), 64'(0));
    force_low = 1'b0;
    finish_cmd("stall");

    // Partial write followed by silence longer than the timeout
    send_byte(8'h57, 3); send_byte(8'h11, 3); send_byte(8'h22, 3); send_byte(8'h33, 0);
    repeat (TMO + 24) @(negedge clk);
    do_hold(1'b0);
    finish_cmd("timeout");

    pool[0] = 32'h00000000; pool[1] = 32'h00000100; pool[2] = 32'h00000104;
    pool[3] = 32'h20000003; pool[4] = 32'hFFFFFFFE; pool[5] = 32'h0000ABC8;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 5)];
      case ($urandom_range(0, 4))
        0: do_write(a, $urandom);
        1: do_read(a);
        2: do_hold(1'b1);
        3: do_hold(1'b0);
        default: begin
          b = 8'($urandom);
          while (b == 8'h57 || b == 8'h52 || b == 8'h48 || b == 8'h47) b = 8'($urandom);
          do_bad(b);
        end
      endcase
      finish_cmd("rand");
    end

    // Asynchronous reset in the middle of the data phase
    do_hold(1'b0); finish_cmd("pre_rst");
    send_byte(8'h57, 2); send_word(32'h00000200);
    send_byte(8'hAA, 2); send_byte(8'hBB, 0);
    #2 rst_n = 1'b0;
    #1 check_reset("async_rst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_hold = 1'b1;
    repeat (2) @(negedge clk);
    finish_cmd("post_rst_idle");
    do_write(32'hFFFFFFFF, 32'hC0FFEE11); finish_cmd("w_top");
    do_read(32'hFFFFFFFC);                finish_cmd("r_top");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
